// File: rtl/morse_tx.sv
// Morse keyer: sends one ITU letter (A-Z) as a timed on/off pattern.
// Supports an inter-letter gap, letter repeat, abort and invalid-code error.
module morse_tx #(
  parameter int TICK_DIV  = 25000000,
  parameter int GAP_UNITS = 2,
  parameter int CNT_W     = 25
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic       rpt,
  input  logic [4:0] sel,
  output logic       out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam int GW = (GAP_UNITS > 1) ? $clog2(GAP_UNITS) : 1;
  localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_MAX =
    GW'((GAP_UNITS > 0) ? GAP_UNITS - 1 : 0);

  // {n, code}: n symbols, first symbol at code[n-1], 1 = dash
  function automatic logic [17:0] lookup(input logic [4:0] s);
    logic [6:0]  nc;
    logic [13:0] p;
    logic [4:0]  l;
    nc = '0;
    p  = '0;
    l  = '0;
    case (s)
      5'd0:    nc = {3'd2, 4'b0001};
      5'd1:    nc = {3'd4, 4'b1000};
      5'd2:    nc = {3'd4, 4'b1010};
      5'd3:    nc = {3'd3, 4'b0100};
      5'd4:    nc = {3'd1, 4'b0000};
      5'd5:    nc = {3'd4, 4'b0010};
      5'd6:    nc = {3'd3, 4'b0110};
      5'd7:    nc = {3'd4, 4'b0000};
      5'd8:    nc = {3'd2, 4'b0000};
      5'd9:    nc = {3'd4, 4'b0111};
      5'd10:   nc = {3'd3, 4'b0101};
      5'd11:   nc = {3'd4, 4'b0100};
      5'd12:   nc = {3'd2, 4'b0011};
      5'd13:   nc = {3'd2, 4'b0010};
      5'd14:   nc = {3'd3, 4'b0111};
      5'd15:   nc = {3'd4, 4'b0110};
      5'd16:   nc = {3'd4, 4'b1101};
      5'd17:   nc = {3'd3, 4'b0010};
      5'd18:   nc = {3'd3, 4'b0000};
      5'd19:   nc = {3'd1, 4'b0001};
      5'd20:   nc = {3'd3, 4'b0001};
      5'd21:   nc = {3'd4, 4'b0001};
      5'd22:   nc = {3'd3, 4'b0011};
      5'd23:   nc = {3'd4, 4'b1001};
      5'd24:   nc = {3'd4, 4'b1011};
      5'd25:   nc = {3'd4, 4'b1100};
      default: nc = '0;
    endcase
    for (int i = 3; i >= 0; i--) begin
      if (i < int'(nc[6:4])) begin
        if (nc[i]) begin
          p = {p[9:0], 4'b1110};
          l = l + 5'd4;
        end else begin
          p = {p[11:0], 2'b10};
          l = l + 5'd2;
        end
      end
    end
    p = p << (5'd14 - l);
    return {p, l[3:0]};
  endfunction

  state_t           state, state_n;
  logic [13:0]      sh, sh_n, lat_pat, lat_pat_n;
  logic [3:0]       bits, bits_n, lat_len, lat_len_n;
  logic [CNT_W-1:0] tick, tick_n;
  logic [GW-1:0]    gcnt, gcnt_n;
  logic             out_n, busy_n, done_n, err_n;
  logic             fin, ld;
  logic [13:0]      lk_pat, ld_pat;
  logic [3:0]       lk_len, ld_len;

  assign {lk_pat, lk_len} = lookup(sel);

  always_comb begin
    state_n   = state;
    sh_n      = sh;
    bits_n    = bits;
    tick_n    = tick;
    gcnt_n    = gcnt;
    lat_pat_n = lat_pat;
    lat_len_n = lat_len;
    out_n     = out;
    busy_n    = busy;
    done_n    = 1'b0;
    err_n     = 1'b0;
    fin       = 1'b0;
    ld        = 1'b0;
    ld_pat    = lk_pat;
    ld_len    = lk_len;
    if (abort) begin
      state_n = IDLE;
      out_n   = 1'b0;
      busy_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          out_n  = 1'b0;
          busy_n = 1'b0;
          if (start) begin
            if (sel < 5'd26) begin
              ld        = 1'b1;
              lat_pat_n = lk_pat;
              lat_len_n = lk_len;
            end else begin
              err_n = 1'b1;
            end
          end
        end
        SEND: begin
          if (tick != '0) begin
            tick_n = tick - 1'b1;
          end else if (bits != 4'd0) begin
            sh_n   = {sh[12:0], 1'b0};
            bits_n = bits - 4'd1;
            tick_n = TICK_MAX;
            out_n  = sh[12];
          end else if (GAP_UNITS > 0) begin
            state_n = GAP;
            out_n   = 1'b0;
            tick_n  = TICK_MAX;
            gcnt_n  = GAP_MAX;
          end else begin
            fin = 1'b1;
          end
        end
        GAP: begin
          if (tick != '0) begin
            tick_n = tick - 1'b1;
          end else if (gcnt != '0) begin
            gcnt_n = gcnt - 1'b1;
            tick_n = TICK_MAX;
          end else begin
            fin = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
      // repeat replays the latched letter, never the live sel
      if (fin) begin
        if (rpt) begin
          ld     = 1'b1;
          ld_pat = lat_pat;
          ld_len = lat_len;
        end else begin
          state_n = IDLE;
          out_n   = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      if (ld) begin
        state_n = SEND;
        sh_n    = ld_pat;
        bits_n  = ld_len - 4'd1;
        tick_n  = TICK_MAX;
        out_n   = ld_pat[13];
        busy_n  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      sh      <= '0;
      bits    <= '0;
      tick    <= '0;
      gcnt    <= '0;
      lat_pat <= '0;
      lat_len <= '0;
      out     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      sh      <= sh_n;
      bits    <= bits_n;
      tick    <= tick_n;
      gcnt    <= gcnt_n;
      lat_pat <= lat_pat_n;
      lat_len <= lat_len_n;
      out     <= out_n;
      busy    <= busy_n;
      done    <= done_n;
      err     <= err_n;
    end
  end

endmodule

// File: tb/tb_morse_tx.sv
// Directed bench for morse_tx: table-driven cycle vectors plus
// hand sequences for repeat, reset mid-letter and full letters.
module tb_morse_tx;

  localparam int T0 = 2;
  localparam int G0 = 3;

  logic       clock;
  logic       reset_n;
  logic       a_start, a_abort, a_rpt;
  logic [4:0] a_sel;
  logic       a_out, a_busy, a_done, a_err;
  logic       b_start, b_abort, b_rpt;
  logic [4:0] b_sel;
  logic       b_out, b_busy, b_done, b_err;

  int checks;
  int failures;

  morse_tx #(.TICK_DIV(T0), .GAP_UNITS(G0), .CNT_W(4)) u0 (
    .clock(clock), .reset_n(reset_n),
    .start(a_start), .abort(a_abort), .rpt(a_rpt), .sel(a_sel),
    .out(a_out), .busy(a_busy), .done(a_done), .err(a_err)
  );

  morse_tx #(.TICK_DIV(1), .GAP_UNITS(0), .CNT_W(2)) u1 (
    .clock(clock), .reset_n(reset_n),
    .start(b_start), .abort(b_abort), .rpt(b_rpt), .sel(b_sel),
    .out(b_out), .busy(b_busy), .done(b_done), .err(b_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       start;
    logic       abort;
    logic [4:0] sel;
    logic       o;
    logic       b;
    logic       d;
    logic       e;
  } vec_t;

  vec_t tv[32];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send_check(input logic [4:0] s, input string m);
    int q[$];
    for (int k = 0; k < m.len(); k++) begin
      if (m[k] == "-") begin
        q.push_back(1); q.push_back(1); q.push_back(1);
      end else begin
        q.push_back(1);
      end
      q.push_back(0);
    end
    a_sel   = s;
    a_start = 1'b1;
    @(posedge clock); #1;
    a_start = 1'b0;
    for (int j = 0; j < q.size() * T0; j++) begin
      chk($sformatf("%s.bit%0d.out", m, j), a_out, q[j / T0]);
      chk($sformatf("%s.bit%0d.busy", m, j), a_busy, 1);
      chk($sformatf("%s.bit%0d.done", m, j), a_done, 0);
      @(posedge clock); #1;
    end
    for (int j = 0; j < G0 * T0; j++) begin
      chk($sformatf("%s.gap%0d.out", m, j), a_out, 0);
      chk($sformatf("%s.gap%0d.busy", m, j), a_busy, 1);
      @(posedge clock); #1;
    end
    chk($sformatf("%s.done", m), a_done, 1);
    chk($sformatf("%s.done_busy", m), a_busy, 0);
    @(posedge clock); #1;
    chk($sformatf("%s.done_clr", m), a_done, 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    {a_start, a_abort, a_rpt, a_sel} = '0;
    {b_start, b_abort, b_rpt, b_sel} = '0;

    for (int i = 0; i < 32; i++) tv[i] = '{0, 0, 5'd0, 0, 0, 0, 0};
    tv[0].start = 1;
    for (int i = 1; i <= 18; i++) tv[i].b = 1;
    for (int i = 1; i <= 2; i++) tv[i].o = 1;
    for (int i = 5; i <= 10; i++) tv[i].o = 1;
    tv[5].start = 1;  tv[5].sel = 5'd25;
    tv[8].start = 1;  tv[8].sel = 5'd31;
    tv[12].start = 1;
    tv[19].d = 1;
    tv[21].start = 1; tv[21].sel = 5'd30;
    tv[22].e = 1;
    tv[24].start = 1; tv[24].abort = 1;
    tv[27].start = 1;
    tv[28].o = 1; tv[28].b = 1;
    tv[29].o = 1; tv[29].b = 1; tv[29].abort = 1;

    #12;
    chk("rst.out", a_out, 0);
    chk("rst.busy", a_busy, 0);
    chk("rst.done", a_done, 0);
    chk("rst.err", a_err, 0);
    chk("rst.b_out", b_out, 0);
    chk("rst.b_busy", b_busy, 0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 32; i++) begin
      chk($sformatf("vec%0d.out", i), a_out, tv[i].o);
      chk($sformatf("vec%0d.busy", i), a_busy, tv[i].b);
      chk($sformatf("vec%0d.done", i), a_done, tv[i].d);
      chk($sformatf("vec%0d.err", i), a_err, tv[i].e);
      a_start = tv[i].start;
      a_abort = tv[i].abort;
      a_sel   = tv[i].sel;
      @(posedge clock); #1;
    end
    {a_start, a_abort, a_sel} = '0;

    b_sel   = 5'd4;
    b_start = 1'b1;
    b_rpt   = 1'b1;
    @(posedge clock); #1;
    b_start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 3) b_sel = 5'd0;
      if (c == 5) b_rpt = 1'b0;
      if (c == 6) b_rpt = 1'b1;
      chk($sformatf("rep%0d.out", c), b_out, c % 2);
      chk($sformatf("rep%0d.busy", c), b_busy, 1);
      chk($sformatf("rep%0d.done", c), b_done, 0);
      if (c == 8) b_rpt = 1'b0;
      @(posedge clock); #1;
    end
    chk("rep.done", b_done, 1);
    chk("rep.done_busy", b_busy, 0);
    chk("rep.done_out", b_out, 0);
    @(posedge clock); #1;
    chk("rep.done_clr", b_done, 0);
    chk("rep.idle_busy", b_busy, 0);

    send_check(5'd24, "-.--");
    send_check(5'd16, "--.-");

    a_sel   = 5'd24;
    a_start = 1'b1;
    @(posedge clock); #1;
    a_start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    chk("y_mid.out", a_out, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst.out", a_out, 0);
    chk("arst.busy", a_busy, 0);
    chk("arst.done", a_done, 0);
    chk("arst.err", a_err, 0);
    #2;
    reset_n = 1'b1;
    send_check(5'd0, ".-");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
